score_digit_renderer: RTL and testbench



---
 rtl/score_pkg.sv | 23 ++
 rtl/bin2bcd_seq.sv | 94 +++++++++
 rtl/score_digit_renderer.sv | 87 ++++++++
 tb/tb_score_digit_renderer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants, digit type and conversion-FSM state encoding for the
// score digit renderer.
package score_pkg;

    localparam int DIGIT_W    = 8;
    localparam int DIGIT_H    = 16;
    localparam int ROM_STRIDE = 16;
    localparam int NUM_DIGITS = 3;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Double-dabble correction applied to each work nibble before a shift.
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Holds one pending request and commits the result atomically.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  score,
    input  logic        score_valid,
    output logic        busy,
    output logic [11:0] bcd
);

    conv_state_t state, state_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  held, held_n;
    logic [11:0] work, work_n;
    logic [11:0] adj;
    logic [11:0] bcd_n;
    logic [2:0]  cnt, cnt_n;
    logic        pending, pending_n;

    assign adj  = {add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};
    assign busy = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n   = state;
        shreg_n   = shreg;
        work_n    = work;
        cnt_n     = cnt;
        held_n    = held;
        pending_n = pending;
        bcd_n     = bcd;

        unique case (state)
            IDLE: begin
                if (score_valid) begin
                    shreg_n = score;
                    work_n  = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                {work_n, shreg_n} = {adj, shreg} << 1;
                cnt_n             = cnt + 3'd1;
                if (cnt == 3'd7) state_n = DONE;
                if (score_valid) begin
                    held_n    = score;
                    pending_n = 1'b1;
                end
            end
            DONE: begin
                bcd_n     = work;
                pending_n = 1'b0;
                // A pulse arriving in DONE is the newest request and wins.
                if (score_valid || pending) begin
                    shreg_n = score_valid ? score : held;
                    work_n  = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            shreg   <= '0;
            held    <= '0;
            work    <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            bcd     <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            held    <= held_n;
            work    <= work_n;
            cnt     <= cnt_n;
            pending <= pending_n;
            bcd     <= bcd_n;
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Renders the 3-digit score field: drives numbers-ROM addresses from the scan
// position and turns the returned glyph row into a per-pixel on flag.
module score_digit_renderer
    import score_pkg::*;
#(
    parameter logic [9:0] X0 = 10'd560,
    parameter logic [9:0] Y0 = 10'd16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  score,
    input  logic        score_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        pixel_on,
    output logic        busy,
    output logic [11:0] bcd
);

    localparam logic [9:0] X1 = X0 + 10'(NUM_DIGITS * DIGIT_W);
    localparam logic [9:0] Y1 = Y0 + 10'(DIGIT_H);

    logic [9:0] rel_x, rel_y;
    logic       in_region;
    logic [1:0] idx;
    logic [2:0] col;
    logic [3:0] row;
    bcd_digit_t hund, tens, ones, digit;
    logic       blank;
    logic       in_region_d, blank_d;
    logic [2:0] col_d;

    bin2bcd_seq u_conv (
        .Clk         (Clk),
        .Reset       (Reset),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .bcd         (bcd)
    );

    assign {hund, tens, ones} = bcd;

    assign rel_x     = DrawX - X0;
    assign rel_y     = DrawY - Y0;
    assign in_region = (DrawX >= X0) && (DrawX < X1) && (DrawY >= Y0) && (DrawY < Y1);
    assign idx       = rel_x[4:3];
    assign col       = rel_x[2:0];
    assign row       = rel_y[3:0];

    // Leading-zero suppression: the ones digit is always drawn.
    always_comb begin
        digit = ones;
        blank = 1'b0;
        unique case (idx)
            2'd0: begin
                digit = hund;
                blank = (hund == 4'd0);
            end
            2'd1: begin
                digit = tens;
                blank = (hund == 4'd0) && (tens == 4'd0);
            end
            default: digit = ones;
        endcase
    end

    assign rom_addr = in_region ? 8'(int'(digit) * ROM_STRIDE + int'(row)) : 8'd0;

    // Region, blank and column are delayed to line up with the ROM read latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            in_region_d <= 1'b0;
            blank_d     <= 1'b0;
            col_d       <= '0;
        end else begin
            in_region_d <= in_region;
            blank_d     <= blank;
            col_d       <= col;
        end
    end

    assign pixel_on = in_region_d & ~blank_d & rom_data[3'd7 - col_d];

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed self-checking bench for score_digit_renderer: a scoreboard queue
// of expected committed BCD values plus render address/pixel checks.
module tb_score_digit_renderer;

    localparam logic [9:0] X0 = 10'd560;
    localparam logic [9:0] Y0 = 10'd16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  score;
    logic        score_valid;
    logic [9:0]  DrawX, DrawY;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        pixel_on;
    logic        busy;
    logic [11:0] bcd;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb[$];

    int busy_cycles = 0;
    int seen_150    = 0;

    score_digit_renderer #(.X0(X0), .Y0(Y0)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .score       (score),
        .score_valid (score_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_on    (pixel_on),
        .busy        (busy),
        .bcd         (bcd)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (busy) busy_cycles++;
        if (bcd == 12'h150) seen_150++;
    end

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int h, t, o;
        h = int'(v) / 100;
        t = (int'(v) / 10) % 10;
        o = int'(v) % 10;
        return {h[3:0], t[3:0], o[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One-cycle score pulse; a request arriving while one is already queued
    // behind the in-flight conversion replaces it (last wins).
    task automatic pulse(input logic [7:0] v);
        score       = v;
        score_valid = 1'b1;
        if (sb.size() >= 2) sb[sb.size() - 1] = to_bcd(v);
        else sb.push_back(to_bcd(v));
        tick();
        score_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [11:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 12'hFFF;
        check(tag, bcd, exp);
    endtask

    task automatic run_to_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic addr_at(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] exp);
        DrawX = x;
        DrawY = y;
        #1;
        check(tag, rom_addr, exp);
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] rdata, input logic exp);
        DrawX = x;
        DrawY = y;
        tick();
        rom_data = rdata;
        #1;
        check(tag, pixel_on, exp);
    endtask

    initial begin
        int n;
        int b0, s0;

        Reset       = 1'b1;
        score       = '0;
        score_valid = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        rom_data    = 8'hFF;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_pixel", pixel_on, 1'b0);
        Reset = 1'b0;
        tick();

        // Score 0: 9-cycle busy, only the ones glyph drawn.
        pulse(8'd0);
        run_to_idle(n);
        check("busy_len_0", n, 9);
        pop_check("bcd_0");
        for (int x = 0; x < 16; x++) pix("blank_lead_0", X0 + 10'(x), Y0 + 10'd5, 8'hFF, 1'b0);
        pix("ones_zero_drawn", X0 + 10'd16, Y0, 8'hFF, 1'b1);
        addr_at("addr_zero_row2", X0 + 10'd16, Y0 + 10'd2, 8'd2);

        // Score 255: exact latency, no partial value before the commit edge.
        pulse(8'd255);
        repeat (8) tick();
        check("no_partial_255", bcd, 12'h000);
        check("busy_before_done", busy, 1'b1);
        tick();
        check("busy_after_done", busy, 1'b0);
        pop_check("bcd_255");
        addr_at("addr_255", X0, Y0 + 10'd3, 8'd35);
        pix("pix_255_col0", X0, Y0 + 10'd3, 8'h80, 1'b1);
        pix("pix_255_col1", X0 + 10'd9, Y0, 8'h40, 1'b1);

        // Score 7: both leading digits blank, bit 7 is the leftmost pixel.
        pulse(8'd7);
        run_to_idle(n);
        pop_check("bcd_7");
        addr_at("addr_7", X0 + 10'd16, Y0 + 10'd15, 8'd127);
        pix("pix_7_col0", X0 + 10'd16, Y0 + 10'd15, 8'h80, 1'b1);
        pix("pix_7_col1", X0 + 10'd17, Y0 + 10'd15, 8'h80, 1'b0);
        pix("tens_blank_7", X0 + 10'd8, Y0, 8'hFF, 1'b0);

        // 42, then 150 and 199 while busy: 199 follows 042 with no gap.
        b0 = busy_cycles;
        s0 = seen_150;
        pulse(8'd42);
        tick();
        tick();
        pulse(8'd150);
        tick();
        pulse(8'd199);
        repeat (3) tick();
        check("no_partial_42", bcd, 12'h007);
        tick();
        pop_check("bcd_42");
        check("busy_no_gap", busy, 1'b1);
        pix("tens_drawn_42", X0 + 10'd8, Y0, 8'hFF, 1'b1);
        pix("hund_blank_42", X0, Y0, 8'hFF, 1'b0);
        run_to_idle(n);
        pop_check("bcd_199");
        check("busy_total_18", busy_cycles - b0, 18);
        check("no_150_seen", seen_150 - s0, 0);
        pix("hund_drawn_199", X0, Y0, 8'hFF, 1'b1);

        // Reset mid-conversion aborts immediately.
        pulse(8'd123);
        repeat (4) tick();
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_bcd", bcd, 12'h000);
        sb.delete();
        tick();
        Reset = 1'b0;
        tick();
        pulse(8'd123);
        run_to_idle(n);
        check("busy_len_123", n, 9);
        pop_check("bcd_123");

        // Field boundaries.
        addr_at("addr_right_edge", X0 + 10'd24, Y0, 8'd0);
        pix("pix_right_edge", X0 + 10'd24, Y0, 8'hFF, 1'b0);
        addr_at("addr_bottom_edge", X0, Y0 + 10'd16, 8'd0);
        pix("pix_bottom_edge", X0, Y0 + 10'd16, 8'hFF, 1'b0);
        pix("pix_left_edge", X0 - 10'd1, Y0, 8'hFF, 1'b0);
        pix("pix_top_edge", X0, Y0 - 10'd1, 8'hFF, 1'b0);
        addr_at("addr_last_in", X0 + 10'd23, Y0 + 10'd15, 8'd63);
        pix("pix_last_in", X0 + 10'd23, Y0 + 10'd15, 8'h01, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
